// File: rtl/spi_master_if.sv
// Bridge-side bundle for spi_master: frame handshake plus the SPI pins.
// master = the spi_master end; slave = whoever drives start/tx_data and the miso line.
interface spi_master_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  miso;
    logic                  sclk;
    logic                  cs;
    logic                  mosi;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, tx_data, miso,
        output sclk, cs, mosi, rx_data, busy, done
    );

    modport slave (
        output start, tx_data, miso,
        input  sclk, cs, mosi, rx_data, busy, done
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: one full-duplex DATA_WIDTH-bit frame per accepted start, sclk = clk / (2*CLK_DIV).
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first; MSB first otherwise.
module spi_master #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CLK_DIV    = 5
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD,
        GAP
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  tick;

    logic                  load_first;
    logic [DATA_WIDTH-1:0] load_rest;
    logic                  next_bit;
    logic [DATA_WIDTH-1:0] tx_next;
    logic [DATA_WIDTH-1:0] rx_next;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    always_comb begin
        load_first = bus.tx_data[DATA_WIDTH-1];
        load_rest  = bus.tx_data << 1;
        next_bit   = tx_shift[DATA_WIDTH-1];
        tx_next    = tx_shift << 1;
        rx_next    = {rx_shift[DATA_WIDTH-2:0], bus.miso};
        if (LSB_FIRST) begin
            load_first = bus.tx_data[0];
            load_rest  = bus.tx_data >> 1;
            next_bit   = tx_shift[0];
            tx_next    = tx_shift >> 1;
            rx_next    = {bus.miso, rx_shift[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bus.sclk    <= 1'b0;
            bus.cs      <= 1'b1;
            bus.mosi    <= 1'b0;
            bus.rx_data <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state != IDLE) begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bus.sclk <= 1'b0;
                    bus.cs   <= 1'b1;
                    if (bus.start) begin
                        tx_shift <= load_rest;
                        rx_shift <= '0;
                        bit_cnt  <= '0;
                        bus.mosi <= load_first;
                        bus.cs   <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (tick) begin
                        bus.sclk <= 1'b1;
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        state    <= TRANSFER;
                    end
                end

                // The last low half-period is spent in TRANSFER before HOLD, so the
                // frame is 2*DATA_WIDTH+2 half-periods from acceptance to done.
                TRANSFER: begin
                    if (tick) begin
                        if (bus.sclk) begin
                            bus.sclk <= 1'b0;
                            if (bit_cnt < BIT_W'(DATA_WIDTH)) begin
                                bus.mosi <= next_bit;
                                tx_shift <= tx_next;
                            end
                        end else if (bit_cnt == BIT_W'(DATA_WIDTH)) begin
                            state <= HOLD;
                        end else begin
                            bus.sclk <= 1'b1;
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                HOLD: begin
                    if (tick) begin
                        bus.cs      <= 1'b1;
                        bus.mosi    <= 1'b0;
                        bus.rx_data <= rx_shift;
                        bus.done    <= 1'b1;
                        state       <= GAP;
                    end
                end

                GAP: begin
                    if (tick) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and slave-model frames, start rejection, resets, back-to-back.
// Build with SPI_MASTER_LSB_FIRST_EN defined to exercise LSB-first ordering.
module tb_spi_master;
    localparam int unsigned DW        = 16;
    localparam int unsigned DIV       = 5;
    localparam int          FRAME_LAT = DIV * (2 * DW + 2);

    logic clk = 1'b0;
    logic rst;

    spi_master_if #(.DATA_WIDTH(DW)) bus ();

    spi_master #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt      = 0;
    int total         = 0;
    int rises         = 0;
    int cs_high_rises = 0;

    logic [DW-1:0] mosi_pat = '0;
    logic          use_slave = 1'b0;
    logic [DW-1:0] slave_tx  = '0;
    logic [DW-1:0] slave_shift = '0;
    logic [DW-1:0] slave_rx  = '0;
    logic          slave_sclk_q = 1'b0;

    assign bus.miso = use_slave ? slave_shift[DW-1] : bus.mosi;

    // mosi_pat holds the bits seen on mosi at each sclk rise, oldest in the MSB
    always @(posedge bus.sclk) begin
        rises = rises + 1;
        if (bus.cs !== 1'b0) cs_high_rises = cs_high_rises + 1;
        mosi_pat = {mosi_pat[DW-2:0], bus.mosi};
    end

    // Clock-synchronous mode-0 slave, MSB first: loads while deselected, shifts on sclk fall
    always @(posedge clk) begin
        slave_sclk_q <= bus.sclk;
        if (bus.cs) slave_shift <= slave_tx;
        else if (!bus.sclk && slave_sclk_q) slave_shift <= slave_shift << 1;
        if (!bus.cs && bus.sclk && !slave_sclk_q) slave_rx <= {slave_rx[DW-2:0], bus.mosi};
    end

    function automatic logic [DW-1:0] exp_pat(input logic [DW-1:0] tx);
        logic [DW-1:0] r;
        r = tx;
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < int'(DW); i++) r[i] = tx[DW-1-i];
`endif
        return r;
    endfunction

    task automatic run_frame(input logic [DW-1:0] tx, input int poke, output int lat);
        @(negedge clk);
        bus.tx_data = tx;
        bus.start   = 1'b1;
        rises       = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (c == poke) begin
                bus.start   = 1'b1;
                bus.tx_data = 16'h0F0F;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic wait_idle;
        for (int c = 0; c < 50; c++) begin
            if (bus.busy === 1'b0) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.tx_data = '0;
        @(negedge clk);
        total++;
        if (bus.sclk !== 1'b0 || bus.cs !== 1'b1 || bus.mosi !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL reset_ctrl: sclk/cs/mosi/busy/done got %b%b%b%b%b expected 01000",
                     bus.sclk, bus.cs, bus.mosi, bus.busy, bus.done);
        else pass_cnt++;
        total++;
        if (bus.rx_data !== 16'h0000) $display("FAIL reset_rx: got %h expected 0000", bus.rx_data);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback;
        int lat;
        int tail;
        run_frame(16'hA5A5, 0, lat);
        total++;
        if (lat !== FRAME_LAT) $display("FAIL lb_latency: got %0d expected %0d", lat, FRAME_LAT);
        else pass_cnt++;
        total++;
        if (rises !== int'(DW)) $display("FAIL lb_rises: got %0d expected %0d", rises, DW);
        else pass_cnt++;
        total++;
        if (bus.rx_data !== 16'hA5A5) $display("FAIL lb_rx: got %h expected a5a5", bus.rx_data);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0) $display("FAIL done_pulse: got %b expected 0", bus.done);
        else pass_cnt++;
        total++;
        if (bus.cs !== 1'b1) $display("FAIL cs_after_done: got %b expected 1", bus.cs);
        else pass_cnt++;
        tail = 1;
        while (bus.busy === 1'b1 && tail < 20) begin
            @(posedge clk);
            #1;
            tail++;
        end
        total++;
        if (tail !== int'(DIV)) $display("FAIL busy_tail: got %0d expected %0d", tail, DIV);
        else pass_cnt++;
    endtask

    task automatic test_reset_mididle;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.rx_data !== 16'h0000) $display("FAIL idle_rst_rx: got %h expected 0000", bus.rx_data);
        else pass_cnt++;
        total++;
        if (bus.cs !== 1'b1 || bus.sclk !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL idle_rst_ctrl: cs/sclk/busy got %b%b%b expected 100", bus.cs, bus.sclk, bus.busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_slave;
        int lat;
        use_slave = 1'b1;
        slave_tx  = 16'h1234;
        slave_rx  = '0;
        run_frame(16'hFF00, 0, lat);
        total++;
        if (lat !== FRAME_LAT) $display("FAIL slv_latency: got %0d expected %0d", lat, FRAME_LAT);
        else pass_cnt++;
        total++;
        if (slave_rx !== exp_pat(16'hFF00)) $display("FAIL slv_rx_at_slave: got %h expected %h", slave_rx, exp_pat(16'hFF00));
        else pass_cnt++;
`ifndef SPI_MASTER_LSB_FIRST_EN
        total++;
        if (bus.rx_data !== 16'h1234) $display("FAIL slv_rx_at_master: got %h expected 1234", bus.rx_data);
        else pass_cnt++;
`endif
        wait_idle();
        use_slave = 1'b0;
    endtask

    task automatic test_ignore_start;
        int lat;
        run_frame(16'h3C3C, 50, lat);
        total++;
        if (lat !== FRAME_LAT) $display("FAIL ign_latency: got %0d expected %0d", lat, FRAME_LAT);
        else pass_cnt++;
        total++;
        if (bus.rx_data !== 16'h3C3C) $display("FAIL ign_rx: got %h expected 3c3c", bus.rx_data);
        else pass_cnt++;
        total++;
        if (rises !== int'(DW)) $display("FAIL ign_rises: got %0d expected %0d", rises, DW);
        else pass_cnt++;
        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.cs !== 1'b1)
            $display("FAIL ign_no_queue: busy/cs got %b%b expected 01", bus.busy, bus.cs);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        int lat;
        @(negedge clk);
        bus.tx_data = 16'hFFFF;
        bus.start   = 1'b1;
        rises       = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (rises >= 3) break;
            @(posedge clk);
            #1;
        end
        total++;
        if (rises !== 3) $display("FAIL mid_third_rise: got %0d expected 3", rises);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.cs !== 1'b1 || bus.sclk !== 1'b0 || bus.busy !== 1'b0 || bus.mosi !== 1'b0)
            $display("FAIL mid_rst_ctrl: cs/sclk/busy/mosi got %b%b%b%b expected 1000",
                     bus.cs, bus.sclk, bus.busy, bus.mosi);
        else pass_cnt++;
        total++;
        if (bus.rx_data !== 16'h0000) $display("FAIL mid_rst_rx: got %h expected 0000", bus.rx_data);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(16'h00FF, 0, lat);
        total++;
        if (lat !== FRAME_LAT) $display("FAIL post_rst_latency: got %0d expected %0d", lat, FRAME_LAT);
        else pass_cnt++;
        total++;
        if (bus.rx_data !== 16'h00FF) $display("FAIL post_rst_rx: got %h expected 00ff", bus.rx_data);
        else pass_cnt++;
        total++;
        if (mosi_pat !== exp_pat(16'h00FF)) $display("FAIL bit_order: got %h expected %h", mosi_pat, exp_pat(16'h00FF));
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_back_to_back;
        int d1;
        int d2;
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        bus.tx_data = 16'h5A5A;
        bus.start   = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                if (d1 < 0) d1 = c;
                else begin
                    d2 = c;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        total++;
        if (d1 < 0 || d2 < 0 || (d2 - d1) !== FRAME_LAT + int'(DIV) + 1)
            $display("FAIL b2b_spacing: got %0d expected %0d", d2 - d1, FRAME_LAT + int'(DIV) + 1);
        else pass_cnt++;
        total++;
        if (bus.rx_data !== 16'h5A5A) $display("FAIL b2b_rx: got %h expected 5a5a", bus.rx_data);
        else pass_cnt++;
        wait_idle();
    endtask

`ifdef SPI_MASTER_LSB_FIRST_EN
    task automatic test_lsb_first;
        int lat;
        run_frame(16'h0001, 0, lat);
        total++;
        if (bus.rx_data !== 16'h0001) $display("FAIL lsb_rx: got %h expected 0001", bus.rx_data);
        else pass_cnt++;
        total++;
        if (mosi_pat !== 16'h8000) $display("FAIL lsb_mosi_first_only: got %h expected 8000", mosi_pat);
        else pass_cnt++;
        wait_idle();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_loopback();
        test_reset_mididle();
        test_slave();
        test_ignore_start();
        test_reset_midframe();
        test_back_to_back();
`ifdef SPI_MASTER_LSB_FIRST_EN
        test_lsb_first();
`endif
        total++;
        if (cs_high_rises !== 0) $display("FAIL sclk_while_deselected: got %0d expected 0", cs_high_rises);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
